mem_responder: RTL and testbench

- Word-addressed memory target on the CPU bus; the responding end of the core's address/data/rw initiator interface.
- Latches one request, inserts a programmable number of wait states, then performs the read or write and pulses ready.
- Sits between the cpu core and on-chip RAM. The initiator holds its request until it sees ready.

---
 rtl/mem_bus_pkg.sv | 15 +
 rtl/wait_state_counter.sv | 29 ++
 rtl/mem_responder.sv | 149 ++++++++++++++
 tb/tb_mem_responder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared CPU-bus target definitions: data width, rw encoding and the
// request-handshake state enum reused by bus targets.
package mem_bus_pkg;

    localparam int   DATA_W   = 32;
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } bus_state_t;

endpackage

// File: rtl/wait_state_counter.sv
// 4-bit loadable down-counter used to time bus wait states; o_zero flags
// that the programmed wait has elapsed.
module wait_state_counter (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_en,
    output logic       o_zero
);

    logic [3:0] r_count;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= 4'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_zero = (r_count == 4'd0);

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory target: accept, wait WAIT_STATES cycles, access RAM, pulse ready.
// Optional address range check enabled by defining MEM_RESPONDER_ADDR_CHECK_EN.
module mem_responder
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              rw,
    input  logic [31:0]       address,
    input  logic [31:0]       datai,
    output logic [DATA_W-1:0] data,
    output logic              ready,
    output logic              err
);

    generate
        if ((WAIT_STATES < 0) || (WAIT_STATES > 15)) begin : g_bad_wait_states
            $error("mem_responder: WAIT_STATES must be in 0..15");
        end
    endgenerate

`ifdef MEM_RESPONDER_ADDR_CHECK_EN
    localparam int CAP_W = 32;
`else
    localparam int CAP_W = ADDR_W;
`endif

    localparam int         WS_M1   = (WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0;
    localparam logic [3:0] WS_LOAD = 4'(WS_M1);
    localparam logic       NO_WAIT = (WAIT_STATES == 0);

    bus_state_t         r_state;
    logic               r_rw;
    logic [CAP_W-1:0]   r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_mem [0:(2**ADDR_W)-1];

    logic               w_accept;
    logic               w_load;
    logic               w_en;
    logic               w_zero;
    logic               w_commit;
    logic               w_op_rw;
    logic [CAP_W-1:0]   w_op_addr;
    logic [DATA_W-1:0]  w_op_wdata;
    logic [ADDR_W-1:0]  w_ram_idx;
    logic               w_in_range;

    assign w_accept = (r_state == IDLE) && req;
    assign w_load   = w_accept && !NO_WAIT;
    assign w_en     = (r_state == BUSY);

    wait_state_counter u_wait (
        .clock      (clock),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (WS_LOAD),
        .i_en       (w_en),
        .o_zero     (w_zero)
    );

    // With no wait states the access happens on the accept edge itself,
    // so the operation must come straight from the bus, not the capture regs.
    always_comb begin
        w_op_rw    = r_rw;
        w_op_addr  = r_addr;
        w_op_wdata = r_wdata;
        if (r_state == IDLE) begin
            w_op_rw    = rw;
            w_op_addr  = address[CAP_W-1:0];
            w_op_wdata = datai;
        end else begin
            w_op_rw    = r_rw;
            w_op_addr  = r_addr;
            w_op_wdata = r_wdata;
        end
    end

    assign w_commit  = !reset && ((w_accept && NO_WAIT) || ((r_state == BUSY) && w_zero));
    assign w_ram_idx = w_op_addr[ADDR_W-1:0];

`ifdef MEM_RESPONDER_ADDR_CHECK_EN
    assign w_in_range = (w_op_addr[31:ADDR_W] == {(32-ADDR_W){1'b0}});
`else
    logic w_unused_addr;
    assign w_unused_addr = ^address[31:ADDR_W];
    assign w_in_range    = 1'b1;
`endif

    // RAM array: contents deliberately not reset.
    always_ff @(posedge clock) begin
        if (w_commit && (w_op_rw == RW_WRITE) && w_in_range) begin
            r_mem[w_ram_idx] <= w_op_wdata;
        end
    end

    // Request FSM, capture registers and registered bus outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_rw    <= 1'b0;
            r_addr  <= {CAP_W{1'b0}};
            r_wdata <= {DATA_W{1'b0}};
            data    <= {DATA_W{1'b0}};
            ready   <= 1'b0;
            err     <= 1'b0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_rw    <= rw;
                        r_addr  <= address[CAP_W-1:0];
                        r_wdata <= datai;
                        r_state <= NO_WAIT ? DONE : BUSY;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                BUSY: begin
                    if (w_zero) begin
                        r_state <= DONE;
                    end else begin
                        r_state <= BUSY;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
            if (w_commit) begin
                ready <= 1'b1;
                err   <= !w_in_range;
                if (w_op_rw == RW_READ) begin
                    data <= w_in_range ? r_mem[w_ram_idx] : {DATA_W{1'b0}};
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one default instance (WAIT_STATES=2)
// and one zero-wait instance; expectations are pushed at accept, popped on ready.
module tb_mem_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        req_a = 1'b0, rw_a = 1'b0;
    logic [31:0] addr_a = 32'd0, wd_a = 32'd0;
    logic [31:0] data_a;
    logic        ready_a, err_a;

    logic        req_b = 1'b0, rw_b = 1'b0;
    logic [31:0] addr_b = 32'd0, wd_b = 32'd0;
    logic [31:0] data_b;
    logic        ready_b, err_b;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          due;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

`ifdef MEM_RESPONDER_ADDR_CHECK_EN
    localparam bit ACHK = 1'b1;
`else
    localparam bit ACHK = 1'b0;
`endif

    localparam logic RD = 1'b1;
    localparam logic WR = 1'b0;

    mem_responder u_dut_a (
        .clock   (clock),
        .reset   (reset),
        .req     (req_a),
        .rw      (rw_a),
        .address (addr_a),
        .datai   (wd_a),
        .data    (data_a),
        .ready   (ready_a),
        .err     (err_a)
    );

    mem_responder #(.WAIT_STATES(0)) u_dut_b (
        .clock   (clock),
        .reset   (reset),
        .req     (req_b),
        .rw      (rw_b),
        .address (addr_b),
        .datai   (wd_b),
        .data    (data_b),
        .ready   (ready_b),
        .err     (err_b)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        exp_t x;
        if (ready_a === 1'b1) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ready_a cyc=%0d data=%h", cyc, data_a);
            end else begin
                x = q_a.pop_front();
                if (data_a !== x.d || err_a !== x.e || cyc != x.due) begin
                    errors++;
                    $display("FAIL resp_a got data=%h err=%b cyc=%0d, expected data=%h err=%b cyc=%0d",
                             data_a, err_a, cyc, x.d, x.e, x.due);
                end
            end
        end
    end

    always @(negedge clock) begin
        exp_t x;
        if (ready_b === 1'b1) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ready_b cyc=%0d data=%h", cyc, data_b);
            end else begin
                x = q_b.pop_front();
                if (data_b !== x.d || err_b !== x.e || cyc != x.due) begin
                    errors++;
                    $display("FAIL resp_b got data=%h err=%b cyc=%0d, expected data=%h err=%b cyc=%0d",
                             data_b, err_b, cyc, x.d, x.e, x.due);
                end
            end
        end
    end

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive a request (req left high) and push its expectation at the accept edge.
    task automatic send(input bit sel, input logic r, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] ed, input logic ee);
        exp_t x;
        @(negedge clock);
        if (sel) begin
            req_b = 1'b1; rw_b = r; addr_b = a; wd_b = wd;
        end else begin
            req_a = 1'b1; rw_a = r; addr_a = a; wd_a = wd;
        end
        @(posedge clock);
        #1;
        x.d   = ed;
        x.e   = ee;
        x.due = cyc + (sel ? 0 : 2);
        if (sel) q_b.push_back(x);
        else     q_a.push_back(x);
    endtask

    task automatic txn(input bit sel, input logic r, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] ed, input logic ee);
        send(sel, r, a, wd, ed, ee);
        if (sel) req_b = 1'b0;
        else     req_a = 1'b0;
        repeat ((sel ? 0 : 2) + 1) @(posedge clock);
    endtask

    initial begin
        logic [31:0] prev_rd;

        repeat (2) @(posedge clock);
        #1;
        check_val("reset_data_a",  data_a, 32'd0);
        check_val("reset_ready_a", {31'd0, ready_a}, 32'd0);
        check_val("reset_err_a",   {31'd0, err_a}, 32'd0);
        check_val("reset_data_b",  data_b, 32'd0);
        check_val("reset_ready_b", {31'd0, ready_b}, 32'd0);
        check_val("reset_err_b",   {31'd0, err_b}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        txn(1'b0, WR, 32'h005, 32'hDEADBEEF, 32'h0000_0000, 1'b0);
        txn(1'b0, RD, 32'h005, 32'h0,        32'hDEADBEEF, 1'b0);
        txn(1'b0, WR, 32'h00A, 32'hA5A55A5A, 32'hDEADBEEF, 1'b0);

        // Inputs change during BUSY and req stays high through DONE.
        send(1'b0, RD, 32'h00A, 32'h0, 32'hA5A55A5A, 1'b0);
        @(negedge clock);
        req_a = 1'b1; rw_a = WR; addr_a = 32'h005; wd_a = 32'h0;
        repeat (2) @(negedge clock);
        req_a = 1'b0;
        repeat (2) @(posedge clock);
        txn(1'b0, RD, 32'h005, 32'h0, 32'hDEADBEEF, 1'b0);

        txn(1'b0, WR, 32'h000, 32'h00001111, 32'hDEADBEEF, 1'b0);
        txn(1'b0, WR, 32'h400, 32'h12345678, 32'hDEADBEEF, ACHK);
        txn(1'b0, RD, 32'h000, 32'h0, ACHK ? 32'h00001111 : 32'h12345678, 1'b0);
        txn(1'b0, RD, 32'h400, 32'h0, ACHK ? 32'h00000000 : 32'h12345678, ACHK);
        prev_rd = ACHK ? 32'h00000000 : 32'h12345678;
        txn(1'b0, WR, 32'h3FF, 32'hCAFEF00D, prev_rd, 1'b0);
        txn(1'b0, RD, 32'h3FF, 32'h0, 32'hCAFEF00D, 1'b0);

        // Zero-wait instance: req held high across four requests.
        send(1'b1, WR, 32'h010, 32'h000000AA, 32'h0, 1'b0);
        @(posedge clock);
        send(1'b1, WR, 32'h011, 32'h000000BB, 32'h0, 1'b0);
        @(posedge clock);
        send(1'b1, RD, 32'h010, 32'h0, 32'h000000AA, 1'b0);
        @(posedge clock);
        send(1'b1, RD, 32'h011, 32'h0, 32'h000000BB, 1'b0);
        req_b = 1'b0;
        repeat (3) @(posedge clock);

        // Reset during a write's BUSY: no ready, write dropped.
        @(negedge clock);
        req_a = 1'b1; rw_a = WR; addr_a = 32'h005; wd_a = 32'h11112222;
        @(posedge clock);
        #1;
        req_a = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_val("midreset_data_a",  data_a, 32'd0);
        check_val("midreset_ready_a", {31'd0, ready_a}, 32'd0);
        check_val("midreset_err_a",   {31'd0, err_a}, 32'd0);
        check_val("midreset_data_b",  data_b, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(posedge clock);
        txn(1'b0, RD, 32'h005, 32'h0, 32'hDEADBEEF, 1'b0);
        txn(1'b1, RD, 32'h011, 32'h0, 32'h000000BB, 1'b0);

        repeat (5) @(posedge clock);
        check_val("pending_a", q_a.size(), 32'd0);
        check_val("pending_b", q_b.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
